// File: rtl/rast_iter_pkg.sv
// Shared types and helpers for the sample iterator.
//   iter_state_t : sequencer state encoding
//   SS_*         : bit positions inside the one-hot subsample select
//   ss_step      : grid pitch in fixed point for a given subsample select
package rast_iter_pkg;

  typedef enum logic {WAIT, TEST} iter_state_t;

  localparam int SS_1X = 3;
  localparam int SS_2X = 2;
  localparam int SS_4X = 1;
  localparam int SS_8X = 0;

  // One pixel is 1 << radix; each doubling of the subsample rate halves the pitch.
  function automatic logic [31:0] ss_step(input logic [3:0] sub_sample, input int radix);
    int lg2;
    lg2 = 0;
    if (sub_sample[SS_2X]) lg2 = 1;
    if (sub_sample[SS_4X]) lg2 = 2;
    if (sub_sample[SS_8X]) lg2 = 3;
    return 32'd1 << (radix - lg2);
  endfunction

endpackage

// File: rtl/samp_grid_step.sv
// Combinational raster step over a grid-aligned bounding box.
//   i_samp_x/y : current sample
//   i_ll_x/y   : lower-left corner of the box
//   i_ur_x/y   : upper-right corner of the box
//   i_step     : grid pitch
//   o_next_x/y : following sample in raster order (x fastest)
//   o_at_last  : current sample is the upper-right corner
module samp_grid_step #(
  parameter int SIGFIG = 24
) (
  input  logic signed [SIGFIG-1:0] i_samp_x,
  input  logic signed [SIGFIG-1:0] i_samp_y,
  input  logic signed [SIGFIG-1:0] i_ll_x,
  input  logic signed [SIGFIG-1:0] i_ll_y,
  input  logic signed [SIGFIG-1:0] i_ur_x,
  input  logic signed [SIGFIG-1:0] i_ur_y,
  input  logic signed [SIGFIG-1:0] i_step,
  output logic signed [SIGFIG-1:0] o_next_x,
  output logic signed [SIGFIG-1:0] o_next_y,
  output logic                     o_at_last
);

  always_comb begin
    o_next_x = i_samp_x;
    o_next_y = i_samp_y;
    if (i_samp_x < i_ur_x) begin
      o_next_x = i_samp_x + i_step;
    end else begin
      o_next_x = i_ll_x;
      o_next_y = i_samp_y + i_step;
    end
  end

  assign o_at_last = (i_samp_x == i_ur_x) && (i_samp_y == i_ur_y);

endmodule

// File: rtl/samp_iter_ctrl.sv
// Sample iterator between the bbox stage and the sample-test datapath.
// Accepts one triangle plus box, emits every subsample grid point inside the box
// in raster order (one per unheld cycle) and stalls upstream while doing so.
//   clk, rst            : clock, synchronous active-high reset
//   tri_R13S, color_R13U: incoming triangle and color
//   box_R13S            : [0]=LL, [1]=UR, each [0]=x [1]=y
//   validTri_R13H       : incoming triangle valid
//   subSample_RnnnnU    : one-hot subsample rate
//   hold_R14H           : downstream stall
//   halt_RnnnnL         : low = upstream must not advance
//   tri_R14S, color_R14U: triangle under test
//   sample_R14S         : current sample (x,y)
//   validSamp_R14H      : sample valid
//
// state | meaning
// WAIT  | idle, ready to accept a triangle
// TEST  | walking the grid of the latched box
module samp_iter_ctrl
  import rast_iter_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  input  logic                     hold_R14H,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic                     validSamp_R14H
);

  iter_state_t r_state;
  iter_state_t w_next_state;

  logic signed [SIGFIG-1:0] r_tri [VERTS][AXIS];
  logic        [SIGFIG-1:0] r_color [COLORS];
  logic signed [SIGFIG-1:0] r_ll_x, r_ll_y, r_ur_x, r_ur_y;
  logic signed [SIGFIG-1:0] r_samp_x, r_samp_y;
  logic                     r_valid;

  logic signed [SIGFIG-1:0] w_step;
  logic signed [SIGFIG-1:0] w_next_x, w_next_y;
  logic                     w_at_last;
  logic                     w_accept, w_advance, w_drop;

  assign w_step = SIGFIG'(ss_step(subSample_RnnnnU, RADIX));

  samp_grid_step #(.SIGFIG(SIGFIG)) u_grid (
    .i_samp_x  (r_samp_x),
    .i_samp_y  (r_samp_y),
    .i_ll_x    (r_ll_x),
    .i_ll_y    (r_ll_y),
    .i_ur_x    (r_ur_x),
    .i_ur_y    (r_ur_y),
    .i_step    (w_step),
    .o_next_x  (w_next_x),
    .o_next_y  (w_next_y),
    .o_at_last (w_at_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      WAIT: begin
        if (validTri_R13H) begin
          w_accept     = 1'b1;
          w_next_state = TEST;
        end
      end
      TEST: begin
        if (!hold_R14H) begin
          if (!w_at_last) begin
            w_advance = 1'b1;
          end else if (validTri_R13H) begin
            // Back-to-back: next triangle's LL follows this UR with no bubble.
            w_accept = 1'b1;
          end else begin
            w_drop       = 1'b1;
            w_next_state = WAIT;
          end
        end
      end
      default: w_next_state = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          r_tri[v][a] <= '0;
      for (int c = 0; c < COLORS; c++)
        r_color[c] <= '0;
      r_ll_x   <= '0;
      r_ll_y   <= '0;
      r_ur_x   <= '0;
      r_ur_y   <= '0;
      r_samp_x <= '0;
      r_samp_y <= '0;
      r_valid  <= 1'b0;
    end else if (w_accept) begin
      r_tri    <= tri_R13S;
      r_color  <= color_R13U;
      r_ll_x   <= box_R13S[0][0];
      r_ll_y   <= box_R13S[0][1];
      r_ur_x   <= box_R13S[1][0];
      r_ur_y   <= box_R13S[1][1];
      r_samp_x <= box_R13S[0][0];
      r_samp_y <= box_R13S[0][1];
      r_valid  <= 1'b1;
    end else if (w_advance) begin
      r_samp_x <= w_next_x;
      r_samp_y <= w_next_y;
    end else if (w_drop) begin
      r_valid  <= 1'b0;
    end
  end

  // In WAIT upstream may always advance; in TEST only as the last sample leaves.
  assign halt_RnnnnL    = (r_state == WAIT) || (w_at_last && !hold_R14H);
  assign tri_R14S       = r_tri;
  assign color_R14U     = r_color;
  assign sample_R14S[0] = r_samp_x;
  assign sample_R14S[1] = r_samp_y;
  assign validSamp_R14H = r_valid;

  a_ss_onehot: assert property (@(posedge clk) disable iff (rst)
    (r_state == TEST) |-> $onehot(subSample_RnnnnU));

endmodule

// File: tb/tb_samp_iter_ctrl.sv
module tb_samp_iter_ctrl;

  localparam int SIG = 24;

  logic                  clk = 1'b0;
  logic                  rst;
  logic signed [SIG-1:0] tri_in [3][3];
  logic        [SIG-1:0] col_in [3];
  logic signed [SIG-1:0] box_in [2][2];
  logic                  vtri_in;
  logic        [3:0]     ss_in;
  logic                  hold_in;
  logic                  halt_out;
  logic signed [SIG-1:0] tri_out [3][3];
  logic        [SIG-1:0] col_out [3];
  logic signed [SIG-1:0] samp_out [2];
  logic                  vsamp_out;

  samp_iter_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_in),
    .color_R13U       (col_in),
    .box_R13S         (box_in),
    .validTri_R13H    (vtri_in),
    .subSample_RnnnnU (ss_in),
    .hold_R14H        (hold_in),
    .halt_RnnnnL      (halt_out),
    .tri_R14S         (tri_out),
    .color_R14U       (col_out),
    .sample_R14S      (samp_out),
    .validSamp_R14H   (vsamp_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               x;
    int               y;
    bit               last;
    logic [9*SIG-1:0] tri_p;
    logic [3*SIG-1:0] col_p;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_pop  = 0;
  bit   hold_rand  = 1'b0;
  bit   hold_force = 1'b0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Reference: every grid point of the box, rows bottom-up, x fastest.
  task automatic model_push(input int lx, input int ly, input int ux, input int uy,
                            input int step, input logic [9*SIG-1:0] tp,
                            input logic [3*SIG-1:0] cp);
    exp_t e;
    for (int y = ly; y <= uy; y += step) begin
      for (int x = lx; x <= ux; x += step) begin
        e.x = x; e.y = y; e.last = (x == ux) && (y == uy);
        e.tri_p = tp; e.col_p = cp;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 2000; i++) begin
      if (sb_q.size() == 0) return;
      @(posedge clk); #1;
    end
    timeout_fail("drain");
  endtask

  task automatic wait_pop(input int target);
    for (int i = 0; i < 500; i++) begin
      if (n_pop >= target) return;
      @(posedge clk); #1;
    end
    timeout_fail("wait_pop");
  endtask

  task automatic idle();
    vtri_in = 1'b0;
  endtask

  // lg2: 0=1x .. 3=8x. Leaves validTri high so a following call is back-to-back.
  task automatic send_tri(input int lx, input int ly, input int ux, input int uy, input int lg2);
    logic [3:0]       ss;
    logic [9*SIG-1:0] tp;
    logic [3*SIG-1:0] cp;
    ss = 4'b1000 >> lg2;
    if (ss != ss_in) begin
      vtri_in = 1'b0;
      wait_empty();
      ss_in = ss;
    end
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++) begin
        tri_in[v][a] = SIG'($urandom);
        tp[(v*3+a)*SIG +: SIG] = tri_in[v][a];
      end
    for (int c = 0; c < 3; c++) begin
      col_in[c] = SIG'($urandom);
      cp[c*SIG +: SIG] = col_in[c];
    end
    box_in[0][0] = SIG'(lx); box_in[0][1] = SIG'(ly);
    box_in[1][0] = SIG'(ux); box_in[1][1] = SIG'(uy);
    vtri_in = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (halt_out) begin
        @(posedge clk);
        model_push(lx, ly, ux, uy, 1024 >> lg2, tp, cp);
        #1;
        return;
      end
    end
    timeout_fail("accept");
  endtask

  always @(posedge clk) begin
    #2;
    hold_in = hold_rand ? ($urandom_range(0, 3) == 0) : hold_force;
  end

  always @(negedge clk) begin
    exp_t             e;
    logic [9*SIG-1:0] gt;
    logic [3*SIG-1:0] gc;
    if (!rst) begin
      if (vsamp_out) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb_q[0];
          for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
              gt[(v*3+a)*SIG +: SIG] = tri_out[v][a];
          for (int c = 0; c < 3; c++) gc[c*SIG +: SIG] = col_out[c];
          chk("sample_x", int'(samp_out[0]), e.x);
          chk("sample_y", int'(samp_out[1]), e.y);
          chk("halt", halt_out, (!hold_in && e.last) ? 1 : 0);
          chk("tri_match", (gt == e.tri_p) ? 1 : 0, 1);
          chk("color_match", (gc == e.col_p) ? 1 : 0, 1);
          if (!hold_in) begin
            void'(sb_q.pop_front());
            n_pop++;
          end
        end
      end else begin
        chk("idle_halt", halt_out, 1);
        if (sb_q.size() != 0) chk("valid_gap", vsamp_out, 1);
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; vtri_in = 1'b0; ss_in = 4'b1000; hold_in = 1'b0;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++) tri_in[v][a] = '0;
    for (int c = 0; c < 3; c++) col_in[c] = '0;
    for (int b = 0; b < 2; b++) begin box_in[b][0] = '0; box_in[b][1] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", vsamp_out, 0);
    chk("rst_halt", halt_out, 1);
    chk("rst_sample_x", int'(samp_out[0]), 0);
    chk("rst_sample_y", int'(samp_out[1]), 0);
    chk("rst_tri", int'(tri_out[2][2]), 0);
    chk("rst_color", int'(col_out[1]), 0);
    rst = 1'b0;

    // 1x, six samples
    send_tri(0, 0, 2048, 1024, 0); idle(); wait_empty();
    // degenerate box at 4x
    send_tri(512, 512, 512, 512, 2); idle(); wait_empty();
    // back-to-back at 1x
    send_tri(0, 0, 1024, 0, 0);
    send_tri(2048, 2048, 3072, 3072, 0); idle(); wait_empty();
    // hold for 3 cycles on (1024,0)
    base = n_pop;
    send_tri(0, 0, 2048, 1024, 0); idle();
    wait_pop(base + 1);
    hold_force = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    hold_force = 1'b0;
    wait_empty();
    // reset while sample 3 is on the output
    base = n_pop;
    send_tri(0, 0, 2048, 1024, 0); idle();
    wait_pop(base + 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    // 8x, x wraps 256 -> 0
    send_tri(0, 0, 256, 128, 3); idle(); wait_empty();

    // randomized: one-hot rate, box size, gaps and downstream hold
    hold_rand = 1'b1;
    for (int t = 0; t < 30; t++) begin
      int lg2, step, lx, ly;
      lg2  = (t % 5 == 0) ? int'($urandom_range(0, 3)) : lg2_prev(t);
      step = 1024 >> lg2;
      lx   = (int'($urandom_range(0, 8)) - 4) * step;
      ly   = (int'($urandom_range(0, 8)) - 4) * step;
      send_tri(lx, ly, lx + int'($urandom_range(0, 3)) * step,
               ly + int'($urandom_range(0, 2)) * step, lg2);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    idle();
    wait_empty();
    hold_rand = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("end_idle_valid", vsamp_out, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Keeps the rate stable over runs of triangles so most of them go back-to-back.
  function automatic int lg2_prev(input int t);
    case (ss_in)
      4'b1000: lg2_prev = 0;
      4'b0100: lg2_prev = 1;
      4'b0010: lg2_prev = 2;
      default: lg2_prev = 3;
    endcase
    if (t < 0) lg2_prev = 0;
  endfunction

endmodule
